// File: rtl/dmem_boot_loader_pkg.sv
// Shared definitions for the data-memory boot loader: store size code,
// loader state encoding and the load-address helper.
package dmem_boot_loader_pkg;

    // funct3 code of a 32-bit store (SW)
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    // Loader sequencing states; RUN is terminal until reset
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } loader_state_e;

    // Byte address of word number idx counted from base (wraps mod 2^32)
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/dmem_boot_loader_if.sv
// Bus bundle around the boot loader: load stream source, CPU data port
// and the muxed data-memory write port.
interface dmem_boot_loader_if;

    // load stream (valid/ready)
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;

    // CPU data-memory request
    logic        cpu_memwrite;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_funct3;

    // data-memory port
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;

    // side that supplies the stream and CPU requests and watches the memory port
    modport master (
        output ld_valid, ld_data, cpu_memwrite, cpu_addr, cpu_wdata, cpu_funct3,
        input  ld_ready, mem_we, mem_addr, mem_wdata, mem_funct3
    );

    // the loader itself
    modport slave (
        input  ld_valid, ld_data, cpu_memwrite, cpu_addr, cpu_wdata, cpu_funct3,
        output ld_ready, mem_we, mem_addr, mem_wdata, mem_funct3
    );

endinterface

// File: rtl/dmem_boot_loader.sv
// Boot sequencer: keeps the CPU in reset, streams NUM_WORDS words into data
// memory at consecutive word addresses, idles RELEASE_DELAY cycles, then
// releases the CPU and hands it the data-memory write port.
module dmem_boot_loader
    import dmem_boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          NUM_WORDS     = 64,
    parameter int          RELEASE_DELAY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    dmem_boot_loader_if.slave        bus,
    output logic                     cpu_reset,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              word_count
);

    localparam logic [15:0] LAST_IDX   = 16'(NUM_WORDS - 1);
    localparam logic [31:0] DELAY_LOAD = 32'(RELEASE_DELAY - 1);

    loader_state_e state_r;
    logic          cpu_reset_r;
    logic          done_r;
    logic [15:0]   word_count_r;
    logic [31:0]   delay_r;

    logic          hs_s;
    logic          enter_drain_s;
    logic          delay_zero_s;
    logic          ld_ready_s;
    logic          mem_we_s;
    logic [31:0]   mem_addr_s;
    logic [31:0]   mem_wdata_s;
    logic [2:0]    mem_funct3_s;

    // State sequencing plus the registered CPU reset and done flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cpu_reset_r <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cpu_reset_r <= 1'b1;
                    done_r      <= 1'b0;
                    if (start) begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cpu_reset_r <= 1'b1;
                    done_r      <= 1'b0;
                    if (enter_drain_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (delay_zero_s) begin
                        state_r     <= ST_RUN;
                        cpu_reset_r <= 1'b0;
                        done_r      <= 1'b1;
                    end else begin
                        cpu_reset_r <= 1'b1;
                        done_r      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cpu_reset_r <= 1'b0;
                    done_r      <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cpu_reset_r <= 1'b1;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    // Words-written counter and the release delay countdown
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count_r <= 16'd0;
            delay_r      <= 32'd0;
        end else begin
            if (hs_s) begin
                word_count_r <= word_count_r + 16'd1;
            end
            if (enter_drain_s) begin
                delay_r <= DELAY_LOAD;
            end else if ((state_r == ST_DRAIN) && !delay_zero_s) begin
                delay_r <= delay_r - 32'd1;
            end
        end
    end

    // Handshake decode and data-memory port mux (loader in LOAD, CPU in RUN)
    always_comb begin
        ld_ready_s   = 1'b0;
        hs_s         = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = bus.cpu_addr;
        mem_wdata_s  = bus.cpu_wdata;
        mem_funct3_s = bus.cpu_funct3;
        case (state_r)
            ST_LOAD: begin
                ld_ready_s   = 1'b1;
                hs_s         = bus.ld_valid;
                mem_we_s     = bus.ld_valid;
                mem_addr_s   = word_addr(BASE_ADDR, word_count_r);
                mem_wdata_s  = bus.ld_data;
                mem_funct3_s = FUNCT3_SW;
            end
            ST_RUN: begin
                mem_we_s = bus.cpu_memwrite;
            end
            ST_IDLE, ST_DRAIN: begin
                mem_we_s = 1'b0;
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
        // abort and the final handshake both end the load; the word still lands
        if (state_r == ST_LOAD) begin
            enter_drain_s = abort || (hs_s && (word_count_r == LAST_IDX));
        end else begin
            enter_drain_s = 1'b0;
        end
        delay_zero_s = (delay_r == 32'd0);
    end

    assign bus.ld_ready   = ld_ready_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.mem_funct3 = mem_funct3_s;

    assign cpu_reset  = cpu_reset_r;
    assign done       = done_r;
    assign busy       = (state_r == ST_LOAD) || (state_r == ST_DRAIN);
    assign word_count = word_count_r;

endmodule
